// File: rtl/video_pkg.sv
// Shared definitions for the test-pattern video blocks: pattern codes and the
// checker state encoding.
package video_pkg;

  localparam logic [7:0] PAT_NONE    = 8'd0;
  localparam logic [7:0] PAT_BORDER  = 8'd1;
  localparam logic [7:0] PAT_MOIRE_X = 8'd2;
  localparam logic [7:0] PAT_MOIRE_Y = 8'd3;
  localparam logic [7:0] PAT_RAMP    = 8'd4;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEARN = 2'd1,
    CHECK = 2'd2
  } chk_state_t;

  // True for the codes that produce a compare; everything else behaves as PAT_NONE.
  function automatic logic is_checked_pattern(input logic [7:0] code);
    return (code == PAT_BORDER) || (code == PAT_MOIRE_X) ||
           (code == PAT_MOIRE_Y) || (code == PAT_RAMP);
  endfunction

endpackage

// File: rtl/vid_coord_tracker.sv
// Rebuilds pixel/line coordinates from vsync and data-enable, and measures the
// width of each line plus whether all lines of the current frame agree.
module vid_coord_tracker #(
  parameter int X_BITS = 13,
  parameter int Y_BITS = 13
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              vn_in,
  input  logic              dn_in,
  output logic              vs_rise,
  output logic              de_fall,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic [X_BITS-1:0] line_width,
  output logic              line_mismatch,
  output logic              frame_ragged
);

  logic              vn_q_r;
  logic              dn_q_r;
  logic [X_BITS-1:0] x_r;
  logic [Y_BITS-1:0] y_r;
  logic [X_BITS-1:0] line_w_r;
  logic [X_BITS-1:0] first_w_r;
  logic              line_seen_r;
  logic              ragged_r;

  assign vs_rise       = vn_in & ~vn_q_r;
  assign de_fall       = ~dn_in & dn_q_r;
  assign x             = x_r;
  assign y             = y_r;
  assign line_width    = line_w_r;
  assign frame_ragged  = ragged_r;
  assign line_mismatch = de_fall & line_seen_r & (x_r != first_w_r);

  // Edge-detect registers and x/y coordinate counters.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      vn_q_r <= 1'b0;
      dn_q_r <= 1'b0;
      x_r    <= '0;
      y_r    <= '0;
    end else begin
      vn_q_r <= vn_in;
      dn_q_r <= dn_in;
      if (dn_in) begin
        x_r <= x_r + 1'b1;
      end else if (de_fall || vs_rise) begin
        x_r <= '0;
      end
      if (vs_rise) begin
        y_r <= '0;
      end else if (de_fall) begin
        y_r <= y_r + 1'b1;
      end
    end
  end

  // Line width capture; the first line of a frame is the reference for the rest.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      line_w_r    <= '0;
      first_w_r   <= '0;
      line_seen_r <= 1'b0;
      ragged_r    <= 1'b0;
    end else begin
      if (de_fall) begin
        line_w_r <= x_r;
      end
      if (vs_rise) begin
        line_seen_r <= 1'b0;
        ragged_r    <= 1'b0;
      end else if (de_fall) begin
        if (!line_seen_r) begin
          first_w_r   <= x_r;
          line_seen_r <= 1'b1;
        end else if (x_r != first_w_r) begin
          ragged_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pattern_chk.sv
// Receive-side checker for the test-pattern stream: learns frame geometry, then
// compares every active pixel against the selected pattern and counts errors.
module pattern_chk
  import video_pkg::*;
#(
  parameter int B               = 8,
  parameter int X_BITS          = 13,
  parameter int Y_BITS          = 13,
  parameter int FRACTIONAL_BITS = 12,
  parameter int ERR_BITS        = 16
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         vn_in,
  input  logic                         hn_in,
  input  logic                         dn_in,
  input  logic [B-1:0]                 r_in,
  input  logic [B-1:0]                 g_in,
  input  logic [B-1:0]                 b_in,
  input  logic [7:0]                   pattern,
  input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
  input  logic                         clear,
  output logic [X_BITS-1:0]            meas_active_pix,
  output logic [Y_BITS-1:0]            meas_active_lines,
  output logic [15:0]                  frame_count,
  output logic [ERR_BITS-1:0]          error_count,
  output logic [X_BITS-1:0]            first_err_x,
  output logic [Y_BITS-1:0]            first_err_y,
  output logic                         locked,
  output logic                         geom_err
);

  localparam int ACC_W = B + FRACTIONAL_BITS;

  logic              vs_rise_s;
  logic              de_fall_s;
  logic [X_BITS-1:0] x_s;
  logic [Y_BITS-1:0] y_s;
  logic [X_BITS-1:0] line_w_s;
  logic              line_mis_s;
  logic              ragged_s;

  chk_state_t          state_r;
  chk_state_t          state_s;
  logic [X_BITS-1:0]   meas_pix_r;
  logic [Y_BITS-1:0]   meas_lines_r;
  logic                locked_r;
  logic                geom_err_r;
  logic [15:0]         frame_cnt_r;
  logic [ERR_BITS-1:0] err_cnt_r;
  logic [X_BITS-1:0]   first_x_r;
  logic [Y_BITS-1:0]   first_y_r;
  logic [ACC_W-1:0]    acc_r;
  logic                mism_r;
  logic [X_BITS-1:0]   mism_x_r;
  logic [Y_BITS-1:0]   mism_y_r;

  logic                learn_ok_s;
  logic                geom_ok_s;
  logic                learn_done_s;
  logic                frame_pass_s;
  logic                frame_fail_s;
  logic [B-1:0]        exp_s;
  logic                chk_en_s;
  logic                pix_bad_s;
  logic                hit_s;
  logic                unused_s;

  // hsync is carried for completeness; coordinates come from data enable only.
  assign unused_s = hn_in;

  vid_coord_tracker #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_tracker (
    .clk_in       (clk_in),
    .reset        (reset),
    .vn_in        (vn_in),
    .dn_in        (dn_in),
    .vs_rise      (vs_rise_s),
    .de_fall      (de_fall_s),
    .x            (x_s),
    .y            (y_s),
    .line_width   (line_w_s),
    .line_mismatch(line_mis_s),
    .frame_ragged (ragged_s)
  );

  assign learn_ok_s   = (y_s != '0) && !ragged_s;
  assign geom_ok_s    = (line_w_s == meas_pix_r) && (y_s == meas_lines_r) && !ragged_s;
  assign learn_done_s = (state_r == LEARN) && vs_rise_s && learn_ok_s;
  assign frame_pass_s = (state_r == CHECK) && vs_rise_s && geom_ok_s;
  assign frame_fail_s = (state_r == CHECK) && vs_rise_s && !geom_ok_s;

  // Next-state logic; decisions happen only at frame boundaries.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SYNC:    state_s = vs_rise_s ? LEARN : SYNC;
      LEARN:   state_s = learn_done_s ? CHECK : LEARN;
      CHECK:   state_s = frame_fail_s ? LEARN : CHECK;
      default: state_s = SYNC;
    endcase
  end

  // State, learned geometry, frame counter and sticky geometry error.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_r      <= SYNC;
      locked_r     <= 1'b0;
      meas_pix_r   <= '0;
      meas_lines_r <= '0;
      frame_cnt_r  <= '0;
      geom_err_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      locked_r <= (state_s == CHECK);
      if (learn_done_s) begin
        meas_pix_r   <= line_w_s;
        meas_lines_r <= y_s;
      end
      if (clear) begin
        frame_cnt_r <= '0;
      end else if (frame_pass_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (clear) begin
        geom_err_r <= 1'b0;
      end else if (frame_fail_s || ((state_r == CHECK) && line_mis_s)) begin
        geom_err_r <= 1'b1;
      end
    end
  end

  // Ramp accumulator mirrors the generator: restarts every line and on lock-in.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      acc_r <= '0;
    end else if (dn_in) begin
      acc_r <= acc_r + ramp_step;
    end else if (de_fall_s || (vs_rise_s && (state_r != CHECK))) begin
      acc_r <= '0;
    end
  end

  // Expected value of the current pixel and whether it is checked at all.
  always_comb begin
    exp_s    = '0;
    chk_en_s = 1'b0;
    case (pattern)
      PAT_BORDER: begin
        exp_s    = '1;
        chk_en_s = (x_s == '0) || (y_s == '0) ||
                   (x_s == (meas_pix_r - 1'b1)) || (y_s == (meas_lines_r - 1'b1));
      end
      PAT_MOIRE_X: begin
        exp_s    = {B{x_s[0]}};
        chk_en_s = 1'b1;
      end
      PAT_MOIRE_Y: begin
        exp_s    = {B{y_s[0]}};
        chk_en_s = 1'b1;
      end
      PAT_RAMP: begin
        exp_s    = acc_r[ACC_W-1:FRACTIONAL_BITS];
        chk_en_s = 1'b1;
      end
      default: begin
        exp_s    = '0;
        chk_en_s = 1'b0;
      end
    endcase
  end

  assign pix_bad_s = (r_in != exp_s) || (g_in != exp_s) || (b_in != exp_s);
  assign hit_s     = (state_r == CHECK) && dn_in && chk_en_s &&
                     is_checked_pattern(pattern) && pix_bad_s;

  // Stage 1: registered mismatch flag with the coordinate it belongs to.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mism_r   <= 1'b0;
      mism_x_r <= '0;
      mism_y_r <= '0;
    end else begin
      mism_r   <= hit_s;
      mism_x_r <= x_s;
      mism_y_r <= y_s;
    end
  end

  // Stage 2: saturating error count and first-error capture; clear has priority.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      err_cnt_r <= '0;
      first_x_r <= '0;
      first_y_r <= '0;
    end else if (clear) begin
      err_cnt_r <= '0;
      first_x_r <= '0;
      first_y_r <= '0;
    end else if (mism_r) begin
      if (err_cnt_r != {ERR_BITS{1'b1}}) begin
        err_cnt_r <= err_cnt_r + 1'b1;
      end
      if (err_cnt_r == '0) begin
        first_x_r <= mism_x_r;
        first_y_r <= mism_y_r;
      end
    end
  end

  assign meas_active_pix   = meas_pix_r;
  assign meas_active_lines = meas_lines_r;
  assign frame_count       = frame_cnt_r;
  assign error_count       = err_cnt_r;
  assign first_err_x       = first_x_r;
  assign first_err_y       = first_y_r;
  assign locked            = locked_r;
  assign geom_err          = geom_err_r;

endmodule

// File: tb/tb_pattern_chk.sv
// Directed self-checking bench for pattern_chk: drives synthetic frames with
// known-good pattern data and planted errors, and checks status/counters.
module tb_pattern_chk;

  logic        clk;
  logic        rst_n;
  logic        vn, hn, dn;
  logic [7:0]  r, g, b;
  logic [7:0]  pattern;
  logic [19:0] ramp_step;
  logic        clear;
  logic [12:0] meas_active_pix;
  logic [12:0] meas_active_lines;
  logic [15:0] frame_count;
  logic [15:0] error_count;
  logic [12:0] first_err_x;
  logic [12:0] first_err_y;
  logic        locked;
  logic        geom_err;

  int checks = 0;
  int errors = 0;

  int         inj_x [2];
  int         inj_y [2];
  logic [7:0] inj_v [2];
  bit         inj_en[2];
  bit         lat_en;
  int         lat_base;
  int         good_prefix;

  pattern_chk dut (
    .clk_in           (clk),
    .reset            (rst_n),
    .vn_in            (vn),
    .hn_in            (hn),
    .dn_in            (dn),
    .r_in             (r),
    .g_in             (g),
    .b_in             (b),
    .pattern          (pattern),
    .ramp_step        (ramp_step),
    .clear            (clear),
    .meas_active_pix  (meas_active_pix),
    .meas_active_lines(meas_active_lines),
    .frame_count      (frame_count),
    .error_count      (error_count),
    .first_err_x      (first_err_x),
    .first_err_y      (first_err_y),
    .locked           (locked),
    .geom_err         (geom_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Correct pixel value the generator would produce.
  function automatic logic [7:0] model_pix(input logic [7:0] pat, input int x, input int y,
                                           input int w, input int h, input logic [19:0] acc);
    case (pat)
      8'd1:    return (x == 0 || y == 0 || x == w - 1 || y == h - 1) ? 8'hFF : 8'h40;
      8'd2:    return (x % 2 == 1) ? 8'hFF : 8'h00;
      8'd3:    return (y % 2 == 1) ? 8'hFF : 8'h00;
      8'd4:    return acc[19:12];
      default: return 8'h00;
    endcase
  endfunction

  task automatic vsync();
    @(negedge clk); vn = 1'b1; dn = 1'b0; hn = 1'b1;
    @(negedge clk);
    @(negedge clk); vn = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive_lines(input int w, input int h, input int blank, input bit inv);
    logic [19:0] acc;
    logic [7:0]  pix;
    for (int yy = 0; yy < h; yy++) begin
      acc = 20'd0;
      for (int xx = 0; xx < w; xx++) begin
        @(negedge clk);
        if (lat_en && yy == inj_y[0] && xx == inj_x[0] + 1) begin
          checks++;
          if (error_count !== lat_base[15:0]) begin
            errors++; $display("FAIL latency_1cyc: error_count %0d, want %0d", error_count, lat_base);
          end
        end
        if (lat_en && yy == inj_y[0] && xx == inj_x[0] + 2) begin
          checks++;
          if (error_count !== lat_base[15:0] + 16'd1) begin
            errors++; $display("FAIL latency_2cyc: error_count %0d, want %0d", error_count, lat_base + 1);
          end
        end
        pix = model_pix(pattern, xx, yy, w, h, acc);
        if (inv && !(yy == 0 && xx < good_prefix)) pix = ~pix;
        for (int k = 0; k < 2; k++)
          if (inj_en[k] && inj_x[k] == xx && inj_y[k] == yy) pix = inj_v[k];
        dn = 1'b1; hn = 1'b0; r = pix; g = pix; b = pix;
        acc = acc + ramp_step;
      end
      for (int k = 0; k < blank; k++) begin
        @(negedge clk); dn = 1'b0; hn = 1'b1; r = 8'h00; g = 8'h00; b = 8'h00;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({meas_active_pix, meas_active_lines, frame_count, error_count, first_err_x, first_err_y,
         locked, geom_err} !== 88'd0) begin
      errors++; $display("FAIL reset_outputs: nonzero output during reset (frame_count %0d error_count %0d locked %0b), want all 0",
                         frame_count, error_count, locked);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_moire_x();
    pattern = 8'd2;
    vsync(); drive_lines(8, 4, 4, 1'b0); vsync();
    checks++; if (meas_active_pix !== 13'd8) begin errors++; $display("FAIL learn_pix: got %0d want 8", meas_active_pix); end
    checks++; if (meas_active_lines !== 13'd4) begin errors++; $display("FAIL learn_lines: got %0d want 4", meas_active_lines); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL learn_locked: got %0b want 1", locked); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL learn_frames: got %0d want 0", frame_count); end
    for (int f = 0; f < 3; f++) begin drive_lines(8, 4, 4, 1'b0); vsync(); end
    checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL moirex_frames: got %0d want 3", frame_count); end
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL moirex_errors: got %0d want 0", error_count); end
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL moirex_geom: got %0b want 0", geom_err); end
  endtask

  task automatic test_ramp();
    pattern = 8'd4; ramp_step = 20'h00800;
    inj_x[0] = 4; inj_y[0] = 2; inj_v[0] = 8'd5; inj_en[0] = 1'b1;
    lat_en = 1'b1; lat_base = 0;
    drive_lines(8, 4, 4, 1'b0);
    lat_en = 1'b0; inj_en[0] = 1'b0;
    vsync();
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL ramp_errors: got %0d want 1", error_count); end
    checks++; if (first_err_x !== 13'd4) begin errors++; $display("FAIL ramp_first_x: got %0d want 4", first_err_x); end
    checks++; if (first_err_y !== 13'd2) begin errors++; $display("FAIL ramp_first_y: got %0d want 2", first_err_y); end
    checks++; if (frame_count !== 16'd4) begin errors++; $display("FAIL ramp_frames: got %0d want 4", frame_count); end
  endtask

  task automatic test_border();
    pulse_clear();
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL clear_errors: got %0d want 0", error_count); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL clear_frames: got %0d want 0", frame_count); end
    pattern = 8'd1;
    inj_x[0] = 7; inj_y[0] = 3; inj_v[0] = 8'h7F; inj_en[0] = 1'b1;
    inj_x[1] = 3; inj_y[1] = 1; inj_v[1] = 8'h12; inj_en[1] = 1'b1;
    drive_lines(8, 4, 4, 1'b0);
    inj_en[0] = 1'b0; inj_en[1] = 1'b0;
    vsync();
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL border_errors: got %0d want 1", error_count); end
    checks++; if (first_err_x !== 13'd7) begin errors++; $display("FAIL border_first_x: got %0d want 7", first_err_x); end
    checks++; if (first_err_y !== 13'd3) begin errors++; $display("FAIL border_first_y: got %0d want 3", first_err_y); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL border_frames: got %0d want 1", frame_count); end
  endtask

  task automatic test_geometry();
    pattern = 8'd2;
    drive_lines(8, 5, 4, 1'b0); vsync();
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL geom_sticky: got %0b want 1", geom_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL geom_unlock: got %0b want 0", locked); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL geom_frames: got %0d want 1", frame_count); end
    checks++; if (meas_active_lines !== 13'd4) begin errors++; $display("FAIL geom_meas_hold: got %0d want 4", meas_active_lines); end
    drive_lines(8, 5, 4, 1'b0); vsync();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relearn_locked: got %0b want 1", locked); end
    checks++; if (meas_active_lines !== 13'd5) begin errors++; $display("FAIL relearn_lines: got %0d want 5", meas_active_lines); end
    checks++; if (meas_active_pix !== 13'd8) begin errors++; $display("FAIL relearn_pix: got %0d want 8", meas_active_pix); end
    pulse_clear();
    checks++; if (geom_err !== 1'b0) begin errors++; $display("FAIL geom_clear: got %0b want 0", geom_err); end
  endtask

  task automatic test_saturation();
    pattern = 8'd3; good_prefix = 3;
    // 2048x33 frame, all pixels wrong except the first three: 67581 mismatches.
    drive_lines(2048, 33, 1, 1'b1);
    good_prefix = 0;
    vsync();
    checks++; if (error_count !== 16'hFFFF) begin errors++; $display("FAIL sat_errors: got %0h want ffff", error_count); end
    checks++; if (first_err_x !== 13'd3) begin errors++; $display("FAIL sat_first_x: got %0d want 3", first_err_x); end
    checks++; if (first_err_y !== 13'd0) begin errors++; $display("FAIL sat_first_y: got %0d want 0", first_err_y); end
    checks++; if (geom_err !== 1'b1) begin errors++; $display("FAIL sat_geom: got %0b want 1", geom_err); end
    pulse_clear();
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL sat_clear_errors: got %0d want 0", error_count); end
    checks++; if ({first_err_x, first_err_y} !== 26'd0) begin
      errors++; $display("FAIL sat_clear_first: got (%0d,%0d) want (0,0)", first_err_x, first_err_y);
    end
  endtask

  task automatic test_reset_midframe();
    pattern = 8'd2;
    drive_lines(8, 4, 4, 1'b0); vsync();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre_reset_locked: got %0b want 1", locked); end
    drive_lines(8, 1, 4, 1'b0);
    @(negedge clk); dn = 1'b1; r = 8'h00; g = 8'h00; b = 8'h00;
    @(negedge clk); dn = 1'b1; r = 8'h00; g = 8'h00; b = 8'h00; rst_n = 1'b0;
    #1;
    checks++;
    if ({meas_active_pix, meas_active_lines, frame_count, error_count, first_err_x, first_err_y,
         locked, geom_err} !== 88'd0) begin
      errors++; $display("FAIL midframe_reset: outputs nonzero (pix %0d lines %0d locked %0b), want all 0",
                         meas_active_pix, meas_active_lines, locked);
    end
    @(negedge clk); r = 8'hFF; g = 8'hFF; b = 8'hFF;
    @(negedge clk); rst_n = 1'b1;
    drive_lines(8, 2, 4, 1'b1);
    vsync(); drive_lines(8, 4, 4, 1'b1); vsync();
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL learn_no_compare: got %0d want 0", error_count); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL post_reset_locked: got %0b want 1", locked); end
    checks++; if (meas_active_lines !== 13'd4) begin errors++; $display("FAIL post_reset_lines: got %0d want 4", meas_active_lines); end
    drive_lines(8, 4, 4, 1'b1); vsync();
    checks++; if (error_count !== 16'd32) begin errors++; $display("FAIL post_reset_compare: got %0d want 32", error_count); end
    checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL post_reset_frames: got %0d want 1", frame_count); end
  endtask

  initial begin
    rst_n = 1'b0; vn = 1'b0; hn = 1'b0; dn = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    pattern = 8'd0; ramp_step = 20'h00800; clear = 1'b0;
    inj_en[0] = 1'b0; inj_en[1] = 1'b0; lat_en = 1'b0; lat_base = 0; good_prefix = 0;
    inj_x[0] = 0; inj_y[0] = 0; inj_x[1] = 0; inj_y[1] = 0;
    inj_v[0] = 8'h00; inj_v[1] = 8'h00;
    test_reset();
    test_moire_x();
    test_ramp();
    test_border();
    test_geometry();
    test_saturation();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
